// File: rtl/vga_fb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// vga_fb_arbiter_pkg : frame geometry and shared types for the frame arbiter
// Revision: 1.0
// ============================================================================
package vga_fb_arbiter_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_BITS = 19;
  localparam int PIX_BITS  = 12;

  typedef logic [ADDR_BITS-1:0] addr_t;
  typedef logic [PIX_BITS-1:0]  pixel_t;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_FETCH = 2'd1,
    GNT_WRITE = 2'd2
  } grant_e;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    RUN       = 2'd1,
    DONE      = 2'd2
  } fbarb_state_e;

  // True when the word address lands inside the visible frame store.
  function automatic logic addr_in_frame(input addr_t a);
    return a < addr_t'(FRAME_PIX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_fb_arbiter_if.sv
`default_nettype none
// ============================================================================
// vga_fb_arbiter_if : pixel-writer handshake plus single-port frame RAM bus
// Revision: 1.0
// ============================================================================
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 12
);

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_ready;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata;

  modport master (
    input  wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_addr, mem_we, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/vga_fb_arbiter_pixel_fifo.sv
`default_nettype none
// ============================================================================
// vga_fb_arbiter_pixel_fifo : synchronous prefetch FIFO with flush
// Revision: 1.0
// ============================================================================
module vga_fb_arbiter_pixel_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic [WIDTH-1:0]        din,
  input  logic                    pop,
  output logic [WIDTH-1:0]        dout,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    empty,
  output logic                    full
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_depth = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_depth);
  assign level     = r_count;
  assign dout      = r_mem[r_rptr];
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && !full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !flush) r_mem[r_wptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// vga_fb_arbiter : shares one frame RAM between raster prefetch and a writer
// Revision: 1.0
// ============================================================================
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 19,
  parameter int PIX_W      = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WM     = 4,
  parameter int FRAME_LEN  = FRAME_PIX
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_start,
  input  logic             pix_en,
  input  logic             active,
  output logic [PIX_W-1:0] pix_rgb,
  output logic             underflow,
  vga_fb_arbiter_if.master bus
);

  localparam int                LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W:0]    c_depth    = (LVL_W+1)'(FIFO_DEPTH);
  localparam logic [LVL_W:0]    c_low_wm   = (LVL_W+1)'(LOW_WM);
  localparam logic [ADDR_W-1:0] c_last_pix = ADDR_W'(FRAME_LEN - 1);

  fbarb_state_e      r_state;
  fbarb_state_e      w_state_nxt;
  grant_e            w_grant;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic              r_inflight;
  logic [LVL_W-1:0]  w_level;
  logic [LVL_W:0]    w_credit;
  logic              w_empty;
  logic              w_full;
  logic              w_can_fetch;
  logic              w_pop;
  logic [PIX_W-1:0]  w_head;

  vga_fb_arbiter_pixel_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (frame_start),
    .push    (r_inflight),
    .din     (bus.mem_rdata),
    .pop     (w_pop),
    .dout    (w_head),
    .level   (w_level),
    .empty   (w_empty),
    .full    (w_full)
  );

  // Credits count the read in flight so the FIFO can never be over-subscribed.
  assign w_credit = {1'b0, w_level} + {{LVL_W{1'b0}}, r_inflight};
  assign w_pop    = pix_en && active && !w_empty && !frame_start;

  always_comb begin
    w_can_fetch = (r_state == RUN) && (w_credit < c_depth) && !w_full && !frame_start;
    w_grant     = GNT_NONE;
    if (!reset_n)
      w_grant = GNT_NONE;
    else if (w_can_fetch && (w_credit < c_low_wm))
      w_grant = GNT_FETCH;
    else if (bus.wr_valid)
      w_grant = GNT_WRITE;
    else if (w_can_fetch)
      w_grant = GNT_FETCH;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (frame_start)
      w_state_nxt = RUN;
    else if ((w_grant == GNT_FETCH) && (r_fetch_addr == c_last_pix))
      w_state_nxt = DONE;
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.wr_ready  = 1'b0;
    case (w_grant)
      GNT_FETCH: bus.mem_addr = r_fetch_addr;
      GNT_WRITE: begin
        bus.wr_ready  = 1'b1;
        bus.mem_addr  = bus.wr_addr;
        bus.mem_wdata = bus.wr_data;
        bus.mem_we    = addr_in_frame(bus.wr_addr);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= WAIT_SYNC;
    else          r_state <= w_state_nxt;
  end

  // frame_start wins over the pixel strobe: the output pixel simply holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_addr <= '0;
      r_inflight   <= 1'b0;
      pix_rgb      <= '0;
      underflow    <= 1'b0;
    end else begin
      r_inflight <= (w_grant == GNT_FETCH);
      if (frame_start) begin
        r_fetch_addr <= '0;
        underflow    <= 1'b0;
      end else begin
        if (w_grant == GNT_FETCH) r_fetch_addr <= r_fetch_addr + 1'b1;
        if (pix_en) begin
          if (!active) begin
            pix_rgb <= '0;
          end else if (!w_empty) begin
            pix_rgb <= w_head;
          end else begin
            pix_rgb   <= '0;
            underflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_vga_fb_arbiter : randomized bench with a queue-based frame-buffer model
// Revision: 1.0
// ============================================================================
module tb_vga_fb_arbiter;

  localparam int FRAME_LEN = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic        pix_en;
  logic        active;
  logic [11:0] pix_rgb;
  logic        underflow;

  vga_fb_arbiter_if #(.ADDR_W(19), .PIX_W(12)) bus ();

  vga_fb_arbiter #(
    .ADDR_W     (19),
    .PIX_W      (12),
    .FIFO_DEPTH (8),
    .LOW_WM     (4),
    .FRAME_LEN  (FRAME_LEN)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .pix_en      (pix_en),
    .active      (active),
    .pix_rgb     (pix_rgb),
    .underflow   (underflow),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame RAM: unwritten words hold addr[11:0]; read data returns one clk later.
  logic [11:0] ram  [logic [18:0]];
  logic [11:0] mram [logic [18:0]];

  function automatic logic [11:0] ram_rd(input logic [18:0] a);
    return ram.exists(a) ? ram[a] : a[11:0];
  endfunction

  function automatic logic [11:0] mram_rd(input logic [18:0] a);
    return mram.exists(a) ? mram[a] : a[11:0];
  endfunction

  always @(posedge clk) begin
    bus.mem_rdata <= ram_rd(bus.mem_addr);
    if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
  end

  // Reference model: raster pointer, FIFO/in-flight queues, output pixel.
  bit          m_run;
  logic [18:0] m_addr;
  logic [11:0] m_pix;
  bit          m_under;
  logic [11:0] m_fifo [$];
  logic [11:0] m_pend [$];
  int          credit;
  bit          can_f, e_fetch, e_write, e_we;
  logic [18:0] e_addr;

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_mem_we",    32'(bus.mem_we),   32'd0);
      check("rst_mem_addr",  32'(bus.mem_addr), 32'd0);
      check("rst_wr_ready",  32'(bus.wr_ready), 32'd0);
      check("rst_pix_rgb",   32'(pix_rgb),      32'd0);
      check("rst_underflow", 32'(underflow),    32'd0);
      m_run = 0; m_addr = '0; m_pix = '0; m_under = 0;
      m_fifo.delete(); m_pend.delete();
    end else begin
      credit  = m_fifo.size() + m_pend.size();
      can_f   = m_run && credit < 8 && !frame_start;
      e_fetch = 0;
      e_write = 0;
      if (can_f && credit < 4) e_fetch = 1;
      else if (bus.wr_valid)   e_write = 1;
      else if (can_f)          e_fetch = 1;
      e_addr = e_fetch ? m_addr : (e_write ? bus.wr_addr : 19'd0);
      e_we   = e_write && (bus.wr_addr < 19'd307200);

      check("mem_addr",  32'(bus.mem_addr), 32'(e_addr));
      check("mem_we",    32'(bus.mem_we),   32'(e_we));
      check("wr_ready",  32'(bus.wr_ready), 32'(e_write));
      if (e_write) check("mem_wdata", 32'(bus.mem_wdata), 32'(bus.wr_data));
      check("pix_rgb",   32'(pix_rgb),      32'(m_pix));
      check("underflow", 32'(underflow),    32'(m_under));

      if (frame_start) begin
        m_fifo.delete(); m_pend.delete();
        m_addr = '0; m_under = 0; m_run = 1;
      end else begin
        if (pix_en) begin
          if (!active)                 m_pix = '0;
          else if (m_fifo.size() != 0) m_pix = m_fifo.pop_front();
          else begin m_pix = '0; m_under = 1; end
        end
        if (m_pend.size() != 0) m_fifo.push_back(m_pend.pop_front());
        if (e_fetch) begin
          m_pend.push_back(mram_rd(m_addr));
          m_addr = m_addr + 19'd1;
          if (m_addr == 19'(FRAME_LEN)) m_run = 0;
        end
      end
      if (e_we) mram[bus.wr_addr] = bus.wr_data;
    end
  end

  task automatic drive(input logic fs, input logic pe, input logic act, input logic wv,
                       input logic [18:0] wa, input logic [11:0] wd);
    frame_start  = fs;
    pix_en       = pe;
    active       = act;
    bus.wr_valid = wv;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [18:0] rand_addr();
    int r = $urandom_range(0, 99);
    if (r < 2) return 19'd307199;
    if (r < 4) return 19'd307200;
    if (r < 8) return 19'($urandom_range(307201, 524287));
    return 19'($urandom_range(0, 1100));
  endfunction

  task automatic wcyc(input logic fs, input logic pe, input logic act, input logic wv);
    drive(fs, pe, act, wv, rand_addr(), 12'($urandom));
    tick();
  endtask

  logic [18:0] max_addr;

  initial begin
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    drive(0, 0, 0, 1, 19'd5, 12'hF00);
    repeat (3) tick();

    reset_n = 1'b1;
    drive(0, 0, 0, 1, 19'd5, 12'hF00);
    check("lit_wr_ready_idle", 32'(bus.wr_ready), 32'd1);
    check("lit_mem_we_idle",   32'(bus.mem_we),   32'd1);
    check("lit_mem_addr_idle", 32'(bus.mem_addr), 32'd5);
    tick();
    repeat (8) begin drive(0, 0, 0, 1, 19'd5, 12'hF00); tick(); end
    drive(0, 0, 0, 1, 19'd307200, 12'h0AB);
    check("lit_oor_ready", 32'(bus.wr_ready), 32'd1);
    check("lit_oor_we",    32'(bus.mem_we),   32'd0);
    tick();

    drive(1, 0, 1, 0, 19'd0, 12'd0);
    tick();
    max_addr = '0;
    repeat (20) begin
      drive(0, 0, 1, 0, 19'd0, 12'd0);
      if (bus.mem_addr > max_addr) max_addr = bus.mem_addr;
      tick();
    end
    check("lit_fill_last_addr", 32'(max_addr), 32'd7);

    for (int i = 0; i < 240; i++) begin
      drive(i == 200, (i % 4) == 0, 1, 0, 19'd0, 12'd0);
      tick();
      if (i == 0 || i == 4 || i == 8)       check("lit_first_pix",   32'(pix_rgb), 32'(i / 4));
      if (i == 204 || i == 208 || i == 212) check("lit_restart_pix", 32'(pix_rgb), 32'((i - 204) / 4));
      if (i == 196) check("lit_no_underflow", 32'(underflow), 32'd0);
    end

    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 1100; s++) begin
        for (int j = 0; j < 4; j++) begin
          wcyc(s == 0 && j == 0, j == 0, s >= 8 && s < 8 + FRAME_LEN,
               (f == 1) ? 1'b1 : ($urandom_range(0, 9) < 8));
        end
      end
      check("lit_frame_underflow", 32'(underflow), 32'd0);
    end

    wcyc(1, 0, 1, 1);
    for (int i = 0; i < 1100; i++) wcyc(0, 1, 1, 1);
    check("lit_forced_underflow", 32'(underflow), 32'd1);
    wcyc(1, 1, 1, 1);
    check("lit_underflow_cleared", 32'(underflow), 32'd0);
    wcyc(0, 0, 0, 0);

    wcyc(1, 0, 1, 1);
    for (int i = 0; i < 60; i++) wcyc(0, (i % 4) == 0, 1, 1);
    reset_n = 1'b0;
    #1;
    check("lit_rst_pix_rgb",   32'(pix_rgb),      32'd0);
    check("lit_rst_underflow", 32'(underflow),    32'd0);
    check("lit_rst_mem_we",    32'(bus.mem_we),   32'd0);
    check("lit_rst_wr_ready",  32'(bus.wr_ready), 32'd0);
    check("lit_rst_mem_addr",  32'(bus.mem_addr), 32'd0);
    tick();
    repeat (3) wcyc(0, 1, 1, 1);
    reset_n = 1'b1;
    repeat (20) wcyc(0, 0, 0, 0);
    repeat (10) wcyc(0, 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
